// File: rtl/p_ng_cpu_port.sv
// CPU-side port controller for one ping-pong packet buffer: ownership FSM
// (snooper -> CPU -> forwarder) plus the configurable read pipeline to the RAM.
module p_ng_cpu_port #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 64,
    parameter bit          BUF_IN     = 1'b0,
    parameter bit          BUF_OUT    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_done,
    output logic                  buf_free,
    input  logic [ADDR_WIDTH-1:0] word_rd_addra,
    input  logic                  rd_en,
    input  logic                  done,
    input  logic                  done_vld,
    input  logic                  rdy_ack,
    output logic                  done_ack,
    output logic                  rdy,
    output logic                  rdy_vld,
    output logic [DATA_WIDTH-1:0] bigword,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  fwd_rdy,
    input  logic                  fwd_done,
    output logic                  proto_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_READY = 2'd1,
        ST_CPU   = 2'd2,
        ST_FWD   = 2'd3
    } state_t;

    state_t state_q;
    logic   done_ack_q;
    logic   proto_err_q;
    logic   rvalid_q;
    logic   rd_issue;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            done_ack_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            done_ack_q <= done_vld && (state_q == ST_CPU);
            // Out-of-order handshakes only flag an error; they never move the FSM.
            if ((wr_done  && (state_q != ST_EMPTY)) ||
                (rdy_ack  && (state_q != ST_READY)) ||
                (fwd_done && (state_q != ST_FWD)))
                proto_err_q <= 1'b1;
            case (state_q)
                ST_EMPTY: if (wr_done)  state_q <= ST_READY;
                ST_READY: if (rdy_ack)  state_q <= ST_CPU;
                ST_CPU:   if (done_vld) state_q <= done ? ST_FWD : ST_EMPTY;
                ST_FWD:   if (fwd_done) state_q <= ST_EMPTY;
                default:                state_q <= ST_EMPTY;
            endcase
        end
    end

    assign buf_free  = (state_q == ST_EMPTY);
    assign rdy       = (state_q == ST_READY);
    assign rdy_vld   = (state_q == ST_EMPTY) || (state_q == ST_READY);
    assign fwd_rdy   = (state_q == ST_FWD);
    assign done_ack  = done_ack_q;
    assign proto_err = proto_err_q;

    assign rd_issue = rd_en && (state_q == ST_CPU);

    if (BUF_IN) begin : g_buf_in
        logic [ADDR_WIDTH-1:0] addr_q;
        logic                  en_q;
        always_ff @(posedge clk) begin
            if (!rst) begin
                addr_q <= '0;
                en_q   <= 1'b0;
            end else begin
                addr_q <= word_rd_addra;
                en_q   <= rd_issue;
            end
        end
        assign mem_rd_addr = addr_q;
        assign mem_rd_en   = en_q;
    end else begin : g_no_buf_in
        assign mem_rd_addr = word_rd_addra;
        assign mem_rd_en   = rd_issue;
    end

    // Tracks which RAM output cycles carry a real read; state changes do not cancel it.
    always_ff @(posedge clk) begin
        if (!rst) rvalid_q <= 1'b0;
        else      rvalid_q <= mem_rd_en;
    end

    if (BUF_OUT) begin : g_buf_out
        logic [DATA_WIDTH-1:0] bigword_q;
        always_ff @(posedge clk) begin
            if (!rst)          bigword_q <= '0;
            else if (rvalid_q) bigword_q <= mem_rd_data;
        end
        assign bigword = bigword_q;
    end else begin : g_no_buf_out
        // Pass fresh RAM data straight through; the hold register keeps the last word.
        logic [DATA_WIDTH-1:0] hold_q;
        always_ff @(posedge clk) begin
            if (!rst)          hold_q <= '0;
            else if (rvalid_q) hold_q <= mem_rd_data;
        end
        assign bigword = rvalid_q ? mem_rd_data : hold_q;
    end

endmodule

// File: tb/tb_p_ng_cpu_port.sv
// Directed vector bench: two instances (unbuffered and fully buffered) share
// stimulus; each has its own RAM model returning addr*0x11.
module tb_p_ng_cpu_port;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_done, rd_en, done, done_vld, rdy_ack, fwd_done;
    logic [AW-1:0] addr;

    logic          buf_free0, done_ack0, rdy0, rdy_vld0, mem_rd_en0, fwd_rdy0, proto_err0;
    logic [DW-1:0] bigword0, mem_rd_data0;
    logic [AW-1:0] mem_rd_addr0;
    logic          buf_free1, done_ack1, rdy1, rdy_vld1, mem_rd_en1, fwd_rdy1, proto_err1;
    logic [DW-1:0] bigword1, mem_rd_data1;
    logic [AW-1:0] mem_rd_addr1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    p_ng_cpu_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_IN(1'b0), .BUF_OUT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .wr_done(wr_done), .buf_free(buf_free0),
        .word_rd_addra(addr), .rd_en(rd_en), .done(done), .done_vld(done_vld),
        .rdy_ack(rdy_ack), .done_ack(done_ack0), .rdy(rdy0), .rdy_vld(rdy_vld0),
        .bigword(bigword0), .mem_rd_addr(mem_rd_addr0), .mem_rd_en(mem_rd_en0),
        .mem_rd_data(mem_rd_data0), .fwd_rdy(fwd_rdy0), .fwd_done(fwd_done),
        .proto_err(proto_err0));

    p_ng_cpu_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_IN(1'b1), .BUF_OUT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .wr_done(wr_done), .buf_free(buf_free1),
        .word_rd_addra(addr), .rd_en(rd_en), .done(done), .done_vld(done_vld),
        .rdy_ack(rdy_ack), .done_ack(done_ack1), .rdy(rdy1), .rdy_vld(rdy_vld1),
        .bigword(bigword1), .mem_rd_addr(mem_rd_addr1), .mem_rd_en(mem_rd_en1),
        .mem_rd_data(mem_rd_data1), .fwd_rdy(fwd_rdy1), .fwd_done(fwd_done),
        .proto_err(proto_err1));

    always @(posedge clk) begin
        if (mem_rd_en0) mem_rd_data0 <= {{(DW-AW){1'b0}}, mem_rd_addr0} * 64'h11;
        if (mem_rd_en1) mem_rd_data1 <= {{(DW-AW){1'b0}}, mem_rd_addr1} * 64'h11;
    end

    typedef struct {
        logic          wr_done, rdy_ack, done_vld, done, fwd_done, rd_en;
        logic [AW-1:0] addr;
        logic          bf, rdy, rv, fr, da, pe;
        logic [DW-1:0] bw0, bw1;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input int idx, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        wr_done  = v.wr_done;  rdy_ack = v.rdy_ack; done_vld = v.done_vld;
        done     = v.done;     fwd_done = v.fwd_done; rd_en = v.rd_en;
        addr     = v.addr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input vec_t v, input int idx);
        chk("buf_free0", idx, 64'(buf_free0), 64'(v.bf));
        chk("rdy0",      idx, 64'(rdy0),      64'(v.rdy));
        chk("rdy_vld0",  idx, 64'(rdy_vld0),  64'(v.rv));
        chk("fwd_rdy0",  idx, 64'(fwd_rdy0),  64'(v.fr));
        chk("done_ack0", idx, 64'(done_ack0), 64'(v.da));
        chk("proto_err0",idx, 64'(proto_err0),64'(v.pe));
        chk("state_eq1", idx, {buf_free1, rdy1, rdy_vld1, fwd_rdy1, done_ack1, proto_err1},
            {v.bf, v.rdy, v.rv, v.fr, v.da, v.pe});
        chk("bigword0",  idx, bigword0, v.bw0);
        chk("bigword1",  idx, bigword1, v.bw1);
    endtask

    function automatic vec_t mk(input logic [5:0] in, input logic [AW-1:0] a,
                                input logic [5:0] exp, input logic [DW-1:0] b0,
                                input logic [DW-1:0] b1);
        vec_t v;
        {v.wr_done, v.rdy_ack, v.done_vld, v.done, v.fwd_done, v.rd_en} = in;
        v.addr = a;
        {v.bf, v.rdy, v.rv, v.fr, v.da, v.pe} = exp;
        v.bw0 = b0;
        v.bw1 = b1;
        return v;
    endfunction

    initial begin
        vec_t idle;
        // inputs: wr_done rdy_ack done_vld done fwd_done rd_en
        // expect: buf_free rdy rdy_vld fwd_rdy done_ack proto_err
        vecs[0]  = mk(6'b000000, 0, 6'b101000, 0,     0);     // EMPTY idle
        vecs[1]  = mk(6'b100000, 0, 6'b011000, 0,     0);     // -> READY
        vecs[2]  = mk(6'b000001, 9, 6'b011000, 0,     0);     // rd_en gated in READY
        vecs[3]  = mk(6'b010000, 0, 6'b000000, 0,     0);     // -> CPU
        vecs[4]  = mk(6'b000001, 3, 6'b000000, 'h33,  0);
        vecs[5]  = mk(6'b000001, 4, 6'b000000, 'h44,  0);
        vecs[6]  = mk(6'b000001, 5, 6'b000000, 'h55,  'h33);
        vecs[7]  = mk(6'b000000, 0, 6'b000000, 'h55,  'h44);
        vecs[8]  = mk(6'b001100, 0, 6'b000110, 'h55,  'h55);  // accept -> FWD, ack
        vecs[9]  = mk(6'b000001, 7, 6'b000100, 'h55,  'h55);  // rd_en gated in FWD
        vecs[10] = mk(6'b000010, 0, 6'b101000, 'h55,  'h55);  // fwd_done -> EMPTY
        vecs[11] = mk(6'b100000, 0, 6'b011000, 'h55,  'h55);  // back-to-back wr_done
        vecs[12] = mk(6'b011100, 0, 6'b000000, 'h55,  'h55);  // rdy_ack wins over done_vld
        vecs[13] = mk(6'b001000, 0, 6'b101010, 'h55,  'h55);  // reject -> EMPTY, ack
        vecs[14] = mk(6'b000001, 2, 6'b101000, 'h55,  'h55);  // rd_en gated in EMPTY
        vecs[15] = mk(6'b100000, 0, 6'b011000, 'h55,  'h55);
        vecs[16] = mk(6'b100000, 0, 6'b011001, 'h55,  'h55);  // wr_done in READY -> err
        vecs[17] = mk(6'b000000, 0, 6'b011001, 'h55,  'h55);  // sticky
        vecs[18] = mk(6'b010000, 0, 6'b000001, 'h55,  'h55);
        vecs[19] = mk(6'b001000, 0, 6'b101011, 'h55,  'h55);
        vecs[20] = mk(6'b000010, 0, 6'b101001, 'h55,  'h55);  // fwd_done in EMPTY
        idle = mk(6'b000000, 0, 6'b000000, 0, 0);

        rst = 1'b0;
        {wr_done, rdy_ack, done_vld, done, fwd_done, rd_en} = '0;
        addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_rd_en0", -1, 64'(mem_rd_en0), 0);
        chk("rst_mem_rd_en1", -1, 64'(mem_rd_en1), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i]);
            check_state(vecs[i], i);
        end

        // Reset while in FWD with a BUF_IN read still in flight.
        drive(mk(6'b000000, 0, 6'b0, 0, 0));
        drive(mk(6'b100000, 0, 6'b0, 0, 0));
        drive(mk(6'b010000, 0, 6'b0, 0, 0));
        drive(mk(6'b001101, 6, 6'b0, 0, 0));
        chk("flight_fwd", 100, 64'(fwd_rdy1), 1);
        chk("flight_en",  100, 64'(mem_rd_en1), 1);
        @(negedge clk);
        rst = 1'b0;
        {wr_done, rdy_ack, done_vld, done, fwd_done, rd_en} = '0;
        @(posedge clk);
        #1;
        chk("rstfwd_buf_free", 101, 64'(buf_free1), 1);
        chk("rstfwd_rdy_vld",  101, 64'(rdy_vld1), 1);
        chk("rstfwd_fwd_rdy",  101, 64'(fwd_rdy1), 0);
        chk("rstfwd_bigword",  101, bigword1, 0);
        chk("rstfwd_mem_en",   101, 64'(mem_rd_en1), 0);
        chk("rstfwd_proto",    101, 64'(proto_err0), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(idle);
            chk("stale_bigword1", 102 + k, bigword1, 0);
            chk("stale_bigword0", 102 + k, bigword0, 0);
        end

        // Back-to-back reads on the buffered instance: exactly 3 cycles, no bubbles.
        drive(mk(6'b100000, 0, 6'b0, 0, 0));
        drive(mk(6'b010000, 0, 6'b0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            logic [AW-1:0] a;
            a = AW'(k < 6 ? 10 + k : 0);
            drive(mk(k < 6 ? 6'b000001 : 6'b000000, a, 6'b0, 0, 0));
            if (k >= 2)
                chk("sweep_bigword1", 200 + k, bigword1, 64'(10 + k - 2) * 64'h11);
            else
                chk("sweep_bigword1", 200 + k, bigword1, 0);
            if (k < 6)
                chk("sweep_bigword0", 200 + k, bigword0, 64'(10 + k) * 64'h11);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
